row_transfer_engine: RTL and testbench
======================================

# row_transfer_engine

Sequences one Game of Life generation step's DDR traffic for a single 640-cell row. It sits between the row buffers and the `Ddr` controller. On a start pulse it writes a captured 640-bit row to DDR as 40 16-bit words, then optionally reads another row back as 40 words into a 640-bit read buffer. It drives the controller's request/acknowledge handshakes and inserts refresh requests.

## Interface
- `WORD_W`, 16, DDR data word width in bits
- `WORDS`, 40, words per row; row width is `WORD_W*WORDS` = 640
- `REFRESH_WORD`, 19, word index after whose acknowledge a refresh is requested
- `clk` input 1: single clock, shared with the DDR controller request side
- `rst` input 1: asynchronous, active-high reset
- `start` input 1: one-cycle pulse that begins a transfer; ignored while `busy`
- `doRead` input 1: sampled at `start`; 1 means a read phase follows the write phase
- `writeRowIndex` input 9: row written to DDR, sampled at `start`
- `readRowIndex` input 9: row read from DDR, sampled at `start`
- `writeRow` input 640: row contents, captured at `start`
- `readRow` output 640: assembled read row
- `busy` output 1: high from the cycle after `start` until `done`
- `done` output 1: one-cycle pulse at the end of a transfer
- `write` output 1: DDR write request
- `writeAddress` output 24: write word address
- `writeData` output 16: write word
- `writeAcknowledge` input 1: write word accepted
- `read` output 1: DDR read request
- `readAddress` output 24: read word address
- `readData` input 16: read word, valid with `readAcknowledge`
- `readAcknowledge` input 1: read word returned
- `refresh` output 1: refresh request
- `refreshAcknowledge` input 1: refresh accepted

## Operation
- Address format: `{9'b0, row[8:0], word[5:0]}`. `word` runs 0..39 and never reaches 40..63.
- Word k maps to row bits [16k+15:16k], for both write and read.
- FSM states: IDLE, WRITE, READ, FINISH.
  - IDLE → WRITE on `start`. At that edge: capture `writeRow` into the snapshot register, latch both indices and `doRead`, clear the word counter.
  - WRITE: `write`=1. `writeData` = snapshot slice for the current word. `writeAddress` tracks the counter.
  - On `writeAcknowledge` with word < 39: increment the word counter.
  - On `writeAcknowledge` with word = 39: drop `write` and clear the counter. Go to READ if `doRead`, else FINISH.
  - READ: `read`=1. On `readAcknowledge`, store `readData` into slice `word` of `readRow`.
  - On `readAcknowledge` with word < 39: increment. At word 39: drop `read` and go to FINISH.
  - FINISH: pulse `done` for one cycle, deassert `busy`, return to IDLE.
- Acknowledges are ignored in states where the matching request is low.
- `readRow` holds its value between transfers. Words not yet read keep their old contents.
- `start` while `busy` has no effect. Inputs are not re-sampled.

## Timing
- Reset values: all outputs 0, `readRow` = 0, state IDLE, counter 0.
- `start` at edge N → `busy`, `write`, word-0 address and data valid after edge N.
- Each acknowledge updates address and data at the same edge. The next word is presented the following cycle. Back-to-back acknowledges give one word per cycle.
- Write→read turnaround is zero cycles: `write` falls and `read` rises at the same edge.
- Minimum transfer with continuous acknowledges: 40 write + 40 read + 1 FINISH = 81 cycles after `start`. Write-only: 41 cycles.
- `rst` mid-transfer: requests drop immediately (asynchronously) and the FSM returns to IDLE. No `done` pulse is issued.

## Configuration
- Macro `ROW_TRANSFER_REFRESH_EN`.
- Defined: `refresh` is set at the `start` edge, and again at the acknowledge of word `REFRESH_WORD` in each phase. It is held until `refreshAcknowledge` is sampled high, then cleared.
  - A set and a clear in the same cycle resolve to set.
  - Refresh does not stall the FSM.
- Undefined: `refresh` is tied to 0 and `refreshAcknowledge` is unused.

## Structure
- Shared package: `ROW_W`=640, `WORD_W`=16, `WORDS_PER_ROW`=40, the state encoding, and the address-packing function.
- One sub-module, `row_word_mux`: combinational selection of a 16-bit slice from a 640-bit row by word index. It feeds `writeData`.

## Test plan
- Write-only: `start`, `doRead`=0, `writeRowIndex`=5, `writeRow` word k = k+0x100, ack every cycle → 40 words at addresses 0x140..0x167 with data 0x100..0x127. `done` at cycle 41 and `read` never high.
- Write+read: `writeRowIndex`=479, `readRowIndex`=0, read model returns 0xA000+k → `readRow` word k = 0xA000+k, `readAddress` 0x000..0x027, `done` at cycle 81.
- Sparse acks with random 0–5 cycle gaps → address and data are held stable while waiting, and the sequence is identical to the back-to-back case.
- `start` pulsed again at word 10 with different indices → ignored, and the transfer completes with the original addresses.
- With `ROW_TRANSFER_REFRESH_EN`, delay `refreshAcknowledge` 3 cycles → `refresh` is high at `start`, again after word-19 ack in each phase, and clears exactly one edge after the ack. Without the macro, `refresh` stays 0.
- Assert `rst` at read word 20 → all requests are 0 immediately, `readRow` = 0, and no `done` pulse; a fresh `start` then completes normally.

Source files
------------

// File: rtl/row_transfer_engine_pkg.sv
// Shared constants, FSM encoding and DDR word-address packing for the row transfer engine.
package row_transfer_engine_pkg;

  localparam int ROW_W         = 640;
  localparam int WORD_W        = 16;
  localparam int WORDS_PER_ROW = 40;
  localparam int WORD_IDX_W    = 6;
  localparam int ROW_IDX_W     = 9;
  localparam int ADDR_W        = 24;

  localparam logic [WORD_IDX_W-1:0] LAST_WORD    = WORD_IDX_W'(WORDS_PER_ROW - 1);
  localparam logic [WORD_IDX_W-1:0] REFRESH_WORD = 6'd19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_FINISH
  } state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_IDX_W-1:0] row,
                                                  input logic [WORD_IDX_W-1:0] word);
    return {9'b0, row, word};
  endfunction

endpackage

// File: rtl/row_transfer_engine_row_word_mux.sv
// Combinational pick of one 16-bit word out of a 640-bit row; indices 40..63 yield zero.
module row_word_mux
  import row_transfer_engine_pkg::*;
(
  input  logic [ROW_W-1:0]      row,
  input  logic [WORD_IDX_W-1:0] word,
  output logic [WORD_W-1:0]     data
);

  always_comb begin
    data = '0;
    for (int k = 0; k < WORDS_PER_ROW; k++) begin
      if (word == WORD_IDX_W'(k)) data = row[k*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/row_transfer_engine.sv
// Writes one 640-bit row to DDR as 40 words, then optionally reads one back; one word per acknowledge.
// Optional refresh requests are enabled by defining ROW_TRANSFER_REFRESH_EN.
module row_transfer_engine
  import row_transfer_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 doRead,
  input  logic [ROW_IDX_W-1:0] writeRowIndex,
  input  logic [ROW_IDX_W-1:0] readRowIndex,
  input  logic [ROW_W-1:0]     writeRow,
  output logic [ROW_W-1:0]     readRow,
  output logic                 busy,
  output logic                 done,
  output logic                 write,
  output logic [ADDR_W-1:0]    writeAddress,
  output logic [WORD_W-1:0]    writeData,
  input  logic                 writeAcknowledge,
  output logic                 read,
  output logic [ADDR_W-1:0]    readAddress,
  input  logic [WORD_W-1:0]    readData,
  input  logic                 readAcknowledge,
  output logic                 refresh,
  input  logic                 refreshAcknowledge
);

  state_e                state_q, state_d;
  logic [WORD_IDX_W-1:0] word_q, word_d;
  logic [ROW_W-1:0]      snap_q, snap_d;
  logic [ROW_W-1:0]      read_row_q, read_row_d;
  logic [ROW_IDX_W-1:0]  wr_row_q, wr_row_d;
  logic [ROW_IDX_W-1:0]  rd_row_q, rd_row_d;
  logic                  do_read_q, do_read_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  write_q, write_d;
  logic                  read_q, read_d;
  logic                  refresh_set;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    snap_d      = snap_q;
    read_row_d  = read_row_q;
    wr_row_d    = wr_row_q;
    rd_row_d    = rd_row_q;
    do_read_d   = do_read_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    write_d     = write_q;
    read_d      = read_q;
    refresh_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WRITE;
          snap_d      = writeRow;
          wr_row_d    = writeRowIndex;
          rd_row_d    = readRowIndex;
          do_read_d   = doRead;
          word_d      = '0;
          busy_d      = 1'b1;
          write_d     = 1'b1;
          refresh_set = 1'b1;
        end
      end
      ST_WRITE: begin
        if (writeAcknowledge) begin
          refresh_set = (word_q == REFRESH_WORD);
          if (word_q == LAST_WORD) begin
            write_d = 1'b0;
            word_d  = '0;
            if (do_read_q) begin
              state_d = ST_READ;
              read_d  = 1'b1;
            end else begin
              state_d = ST_FINISH;
              done_d  = 1'b1;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        if (readAcknowledge) begin
          refresh_set = (word_q == REFRESH_WORD);
          for (int k = 0; k < WORDS_PER_ROW; k++) begin
            if (word_q == WORD_IDX_W'(k)) read_row_d[k*WORD_W +: WORD_W] = readData;
          end
          if (word_q == LAST_WORD) begin
            read_d  = 1'b0;
            word_d  = '0;
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      ST_FINISH: begin
        // busy stays up through the done cycle so a start seen with done is still ignored
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      snap_q     <= '0;
      read_row_q <= '0;
      wr_row_q   <= '0;
      rd_row_q   <= '0;
      do_read_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      snap_q     <= snap_d;
      read_row_q <= read_row_d;
      wr_row_q   <= wr_row_d;
      rd_row_q   <= rd_row_d;
      do_read_q  <= do_read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      write_q    <= write_d;
      read_q     <= read_d;
    end
  end

  row_word_mux u_word_mux (
    .row  (snap_q),
    .word (word_q),
    .data (writeData)
  );

  assign readRow      = read_row_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign write        = write_q;
  assign read         = read_q;
  assign writeAddress = pack_addr(wr_row_q, word_q);
  assign readAddress  = pack_addr(rd_row_q, word_q);

`ifdef ROW_TRANSFER_REFRESH_EN
  logic refresh_q, refresh_d;

  // a new request arriving with the acknowledge of the previous one wins
  always_comb begin
    refresh_d = refresh_q;
    if (refreshAcknowledge) refresh_d = 1'b0;
    if (refresh_set)        refresh_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) refresh_q <= 1'b0;
    else     refresh_q <= refresh_d;
  end

  assign refresh = refresh_q;
`else
  logic unused_refresh;
  assign unused_refresh = refreshAcknowledge ^ refresh_set;
  assign refresh        = 1'b0;
`endif

endmodule

// File: tb/tb_row_transfer_engine.sv
// Bench for row_transfer_engine: directed and randomized transfers against a word-level DDR model.
module tb_row_transfer_engine;
  import row_transfer_engine_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, doRead;
  logic [8:0]   writeRowIndex, readRowIndex;
  logic [639:0] writeRow, readRow;
  logic         busy, done, write, read, refresh;
  logic [23:0]  writeAddress, readAddress;
  logic [15:0]  writeData, readData;
  logic         writeAcknowledge, readAcknowledge, refreshAcknowledge;

  row_transfer_engine dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .doRead             (doRead),
    .writeRowIndex      (writeRowIndex),
    .readRowIndex       (readRowIndex),
    .writeRow           (writeRow),
    .readRow            (readRow),
    .busy               (busy),
    .done               (done),
    .write              (write),
    .writeAddress       (writeAddress),
    .writeData          (writeData),
    .writeAcknowledge   (writeAcknowledge),
    .read               (read),
    .readAddress        (readAddress),
    .readData           (readData),
    .readAcknowledge    (readAcknowledge),
    .refresh            (refresh),
    .refreshAcknowledge (refreshAcknowledge)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  logic         exp_ref;
  int           ref_wait;
  logic [639:0] model_rd_row;
  logic [15:0]  wr_words [40];
  logic [15:0]  rd_words [40];

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [639:0] rand_row();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Refresh controller model: acknowledges on the third cycle it sees refresh high.
  task automatic drive_ref_ack(input bit set_evt);
    logic ack;
    ack = 1'b0;
    if (refresh) begin
      ref_wait++;
      if (ref_wait >= 3) begin
        ack      = 1'b1;
        ref_wait = 0;
      end
    end else begin
      ref_wait = 0;
    end
    refreshAcknowledge = ack;
    if (exp_ref && ack) exp_ref = 1'b0;
`ifdef ROW_TRANSFER_REFRESH_EN
    if (set_evt) exp_ref = 1'b1;
`endif
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; writeAcknowledge = 1'b0; readAcknowledge = 1'b0;
      check("idle_refresh", refresh, exp_ref);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_reqs", {write, read}, 0);
      drive_ref_ack(1'b0);
    end
  endtask

  task automatic run_transfer(input logic do_rd, input logic [8:0] wi, input logic [8:0] ri,
                              input logic [639:0] row, input int max_gap,
                              input int inject_at, input int rst_at);
    int widx, ridx, gap, cyc, done_cyc, inj;
    bit set_evt;
    widx = 0; ridx = 0; cyc = 0; done_cyc = -1; inj = inject_at;
    for (int k = 0; k < 40; k++) wr_words[k] = row[k*16 +: 16];

    @(negedge clk);
    writeAcknowledge = 1'b0; readAcknowledge = 1'b0;
    check("pre_busy", busy, 0);
    check("pre_refresh", refresh, exp_ref);
    start = 1'b1; doRead = do_rd; writeRowIndex = wi; readRowIndex = ri; writeRow = row;
    drive_ref_ack(1'b1);
    gap = $urandom_range(0, max_gap);

    while (done_cyc < 0 && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0; writeAcknowledge = 1'b0; readAcknowledge = 1'b0;
      readData = 16'($urandom);
      cyc++;
      set_evt = 1'b0;
      check("refresh", refresh, exp_ref);
      if (done) begin
        done_cyc = cyc;
        check("done_widx", widx, 40);
        check("done_ridx", ridx, do_rd ? 40 : 0);
        check("done_reqs", {write, read}, 0);
      end else begin
        check("busy", busy, 1);
        if (widx < 40) begin
          check("write_req", write, 1);
          check("read_in_wph", read, 0);
          check("waddr", writeAddress, 24'(wi) * 64 + widx);
          check("wdata", writeData, wr_words[widx]);
          readAcknowledge = 1'($urandom_range(0, 1));
          if (widx == inj) begin
            start = 1'b1; writeRowIndex = ~wi; readRowIndex = ~ri; writeRow = ~row; doRead = ~do_rd;
            inj = -1;
          end
          if (gap == 0) begin
            writeAcknowledge = 1'b1;
            set_evt = (widx == 19);
            widx++;
            gap = $urandom_range(0, max_gap);
          end else gap--;
        end else if (do_rd && ridx < 40) begin
          check("write_in_rph", write, 0);
          check("read_req", read, 1);
          check("raddr", readAddress, 24'(ri) * 64 + ridx);
          if (ridx == rst_at) begin
            #2 rst = 1'b1;
            #1;
            check("rst_reqs", {write, read, refresh}, 0);
            check("rst_busy_done", {busy, done}, 0);
            check("rst_readrow", readRow, 0);
            model_rd_row = '0; exp_ref = 1'b0; ref_wait = 0; refreshAcknowledge = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            idle_cycles(4);
            return;
          end
          writeAcknowledge = 1'($urandom_range(0, 1));
          if (gap == 0) begin
            readAcknowledge = 1'b1;
            readData = rd_words[ridx];
            model_rd_row[ridx*16 +: 16] = rd_words[ridx];
            set_evt = (ridx == 19);
            ridx++;
            gap = $urandom_range(0, max_gap);
          end else gap--;
        end else begin
          check("done_missing", done, 1);
          done_cyc = cyc;
        end
      end
      drive_ref_ack(set_evt);
    end

    if (done_cyc < 0) check("timeout", 0, 1);
    else if (max_gap == 0) check("latency", done_cyc, do_rd ? 81 : 41);

    @(negedge clk);
    writeAcknowledge = 1'b0; readAcknowledge = 1'b0;
    check("post_refresh", refresh, exp_ref);
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("readrow", readRow, model_rd_row);
    drive_ref_ack(1'b0);
  endtask

  initial begin
    logic [639:0] row;
    rst = 1'b1; start = 1'b0; doRead = 1'b0; writeRowIndex = '0; readRowIndex = '0;
    writeRow = '0; readData = '0; writeAcknowledge = 1'b0; readAcknowledge = 1'b0;
    refreshAcknowledge = 1'b0; exp_ref = 1'b0; ref_wait = 0; model_rd_row = '0;

    repeat (2) @(negedge clk);
    check("rst_flags", {busy, done, write, read, refresh}, 0);
    check("rst_addrs", {writeAddress, readAddress, writeData}, 0);
    check("rst_readrow", readRow, 0);
    rst = 1'b0;
    idle_cycles(2);

    for (int k = 0; k < 40; k++) row[k*16 +: 16] = 16'h100 + 16'(k);
    run_transfer(1'b0, 9'd5, 9'd0, row, 0, -1, -1);

    for (int k = 0; k < 40; k++) rd_words[k] = 16'hA000 + 16'(k);
    run_transfer(1'b1, 9'd479, 9'd0, rand_row(), 0, -1, -1);

    for (int k = 0; k < 40; k++) rd_words[k] = 16'($urandom);
    run_transfer(1'b1, 9'd5, 9'd0, row, 5, -1, -1);

    run_transfer(1'b0, 9'd33, 9'd44, rand_row(), 0, -1, -1);

    for (int k = 0; k < 40; k++) rd_words[k] = 16'($urandom);
    run_transfer(1'b1, 9'd100, 9'd200, rand_row(), 2, 10, -1);

    for (int k = 0; k < 40; k++) rd_words[k] = 16'($urandom);
    run_transfer(1'b1, 9'd7, 9'd8, rand_row(), 1, -1, 20);

    for (int k = 0; k < 40; k++) rd_words[k] = 16'($urandom);
    run_transfer(1'b1, 9'd9, 9'd10, rand_row(), 0, -1, -1);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 40; k++) rd_words[k] = 16'($urandom);
      run_transfer(1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom), rand_row(),
                   $urandom_range(0, 3), -1, -1);
      idle_cycles($urandom_range(0, 4));
    end

    idle_cycles(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
